// File: rtl/fibonacci_index_decoder.sv
// ---------------------------------------------------------------------------
// fibonacci_index_decoder
//
// Purpose:
//   Finds where a W-bit value sits in the Fibonacci sequence F(1)=1, F(2)=1,
//   F(3)=2, ... It walks the sequence with the recurrence a,b <= b,a+b, one
//   step per clock. It reports the smallest n with F(n) >= value, and whether
//   the value is exactly F(n). A value of 0 reports index 0, not Fibonacci.
//   A saturating counter tracks how many delivered results were exact hits.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both high. in_ready is high only in IDLE. out_valid
//   is high only in DONE, and out_index/out_is_fib hold steady until
//   out_ready is seen. The producer may hold in_valid high all the time. It
//   is ignored outside IDLE, and in_value is sampled only on the accept edge.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   in_valid     in_value is valid
//   in_ready     block can accept a value (IDLE)
//   in_value     W-bit value to decode
//   out_valid    result valid, held until out_ready
//   out_ready    consumer accepts the result
//   out_index    smallest n>=1 with F(n) >= value (0 when value==0)
//   out_is_fib   1 iff F(out_index) == value
//   hit_count    delivered exact hits, saturating at all-ones
//   state_dbg    current FSM state (0=IDLE, 1=SEARCH, 2=DONE)
// ---------------------------------------------------------------------------
module fibonacci_index_decoder #(
  parameter int W     = 8,
  parameter int IDX_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_is_fib,
  output logic [CNT_W-1:0] hit_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [W-1:0]     value_q;
  // One bit wider than the value. The walk stops at the first term that is
  // >= value, and that term stays below 2^(W+1). Only b can wrap, and only
  // on the final step, where its value is never used.
  logic [W:0]       a_q;
  logic [W:0]       b_q;
  logic [IDX_W-1:0] n_q;

  logic [W:0]       value_ext;
  logic             value_zero;
  logic             reached;
  logic             search_end;
  logic             accept;
  logic             deliver;

  assign value_ext  = {1'b0, value_q};
  assign value_zero = (value_q == '0);
  assign reached    = (a_q >= value_ext);
  assign search_end = value_zero || reached;
  assign state_dbg  = state_q;

  // Next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_SEARCH;
      end
      S_SEARCH: begin
        if (search_end) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept  = in_ready && in_valid;
  assign deliver = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: the search registers and the result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      n_q        <= '0;
      out_index  <= '0;
      out_is_fib <= 1'b0;
    end else if (accept) begin
      value_q <= in_value;
      a_q     <= (W+1)'(1);
      b_q     <= (W+1)'(1);
      n_q     <= IDX_W'(1);
    end else if (state_q == S_SEARCH) begin
      if (value_zero) begin
        out_index  <= '0;
        out_is_fib <= 1'b0;
      end else if (reached) begin
        // The first hit wins, so value 1 reports n=1 and never n=2.
        out_index  <= n_q;
        out_is_fib <= (a_q == value_ext);
      end else begin
        a_q <= b_q;
        b_q <= a_q + b_q;
        n_q <= n_q + IDX_W'(1);
      end
    end
  end

  // Exact-hit counter, updated on the edge that hands the result over
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count <= '0;
    end else if (deliver && out_is_fib && (hit_count != '1)) begin
      hit_count <= hit_count + CNT_W'(1);
    end
  end

endmodule
